// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding and default sizes.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  logic [PW-1:0] w_cand;

  // Scan from the farthest candidate down so the one nearest the pointer wins.
  always_comb begin
    o_valid  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    w_cand   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = PW'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
    o_onehot[o_idx] = o_valid;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer sharing one start/done multiplier among NREQ requesters,
// with a watchdog that turns a missing done into an error response.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic [2*W-1:0]    resp_product,
  output logic              resp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic              mul_done,
  input  logic [2*W-1:0]    mul_product
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_ack;
  logic [2*W-1:0]    r_prod;
  logic              r_err;
  logic              r_start;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [CW-1:0]     r_wdog;

  logic [W-1:0]      w_a [NREQ];
  logic [W-1:0]      w_b [NREQ];
  logic [NREQ-1:0]   w_onehot;
  logic [PW-1:0]     w_idx;
  logic              w_valid;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_a[gi] = a_in[gi*W +: W];
    assign w_b[gi] = b_in[gi*W +: W];
  end

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  // Outputs are set on the transition into the state in which they must be visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ack   <= '0;
      r_prod  <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_wdog  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner <= w_idx;
            r_grant <= w_onehot;
            r_a     <= w_a[w_idx];
            r_b     <= w_b[w_idx];
            r_start <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_start <= 1'b0;
          r_wdog  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            r_prod  <= mul_product;
            r_err   <= 1'b0;
            r_ack   <= r_grant;
            r_state <= RESP;
          end else if (r_wdog == WD_LAST) begin
            r_prod  <= '0;
            r_err   <= 1'b1;
            r_ack   <= r_grant;
            r_state <= RESP;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        RESP: begin
          r_grant <= '0;
          r_ack   <= '0;
          r_err   <= 1'b0;
          r_prod  <= '0;
          r_ptr   <= (r_owner == PTR_LAST) ? '0 : r_owner + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant        = r_grant;
  assign ack          = r_ack;
  assign resp_product = r_prod;
  assign resp_err     = r_err;
  assign busy         = (r_state != IDLE);
  assign mul_start    = r_start;
  assign mul_a        = r_a;
  assign mul_b        = r_b;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter with a 3-cycle multiplier model.
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [15:0] resp_product;
  logic        resp_err;
  logic        busy;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done;
  logic [15:0] mul_product;

  int n_checks;
  int n_pass;
  int cycle;
  int grant_bad;

  // Multiplier model: done arrives 3 cycles after the cycle in which start is high.
  logic        m_en;
  logic        inj_done;
  logic        m_busy;
  logic [1:0]  m_cnt;
  logic        m_done;
  logic [15:0] m_hold;

  mult_share_arbiter #(.NREQ(4), .W(8), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .a_in         (a_in),
    .b_in         (b_in),
    .grant        (grant),
    .ack          (ack),
    .resp_product (resp_product),
    .resp_err     (resp_err),
    .busy         (busy),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_done     (mul_done),
    .mul_product  (mul_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy      <= 1'b0;
      m_cnt       <= 2'd0;
      m_done      <= 1'b0;
      m_hold      <= 16'd0;
      mul_product <= 16'd0;
    end else begin
      m_done <= 1'b0;
      if (mul_start && m_en) begin
        m_busy <= 1'b1;
        m_cnt  <= 2'd1;
        m_hold <= mul_a * mul_b;
      end else if (m_busy) begin
        if (m_cnt == 2'd0) begin
          m_done      <= 1'b1;
          mul_product <= m_hold;
          m_busy      <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 2'd1;
        end
      end
    end
  end

  assign mul_done = m_done | inj_done;

  // Grant must be exactly one-hot while busy and all-zero while idle.
  always @(negedge clk) begin
    if (rst && ((busy && $countones(grant) != 1) || (!busy && grant != 4'd0)))
      grant_bad <= grant_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic wait_ack(input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (ack != 4'd0) begin
        ok = 1'b1;
        $display("txn cycle=%0d ack=%b product=%0d err=%0d", cycle, ack, resp_product, resp_err);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (grant !== 4'd0) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    n_checks++; if (ack !== 4'd0) $display("FAIL reset_ack: got %b want 0000", ack); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (mul_start !== 1'b0) $display("FAIL reset_start: got %b want 0", mul_start); else n_pass++;
    n_checks++; if ({mul_a, mul_b} !== 16'd0) $display("FAIL reset_operands: got %h want 0000", {mul_a, mul_b}); else n_pass++;
    n_checks++; if ({resp_product, resp_err} !== 17'd0) $display("FAIL reset_resp: got %h want 0", {resp_product, resp_err}); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int   t0;
    int   starts;
    logic ok;
    a_in[7:0] = 8'd4;
    b_in[7:0] = 8'd4;
    req = 4'b0001;
    t0 = cycle;
    tick();
    n_checks++; if (grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", grant); else n_pass++;
    n_checks++; if (mul_start !== 1'b1) $display("FAIL single_start: got %b want 1", mul_start); else n_pass++;
    n_checks++; if ({mul_a, mul_b} !== {8'd4, 8'd4}) $display("FAIL single_operands: got %0d,%0d want 4,4", mul_a, mul_b); else n_pass++;
    starts = 1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (mul_start) starts++;
      if (ack != 4'd0) begin
        ok = 1'b1;
        $display("txn cycle=%0d ack=%b product=%0d err=%0d", cycle, ack, resp_product, resp_err);
        break;
      end
    end
    n_checks++; if (ok !== 1'b1) $display("FAIL single_ack_timeout: got no ack want ack within 20 cycles"); else n_pass++;
    n_checks++; if (cycle - t0 != 5) $display("FAIL single_latency: got %0d want 5", cycle - t0); else n_pass++;
    n_checks++; if (ack !== 4'b0001) $display("FAIL single_ack: got %b want 0001", ack); else n_pass++;
    n_checks++; if (resp_product !== 16'd16) $display("FAIL single_product: got %0d want 16", resp_product); else n_pass++;
    n_checks++; if (resp_err !== 1'b0) $display("FAIL single_err: got %b want 0", resp_err); else n_pass++;
    n_checks++; if (grant !== 4'b0001) $display("FAIL single_grant_in_resp: got %b want 0001", grant); else n_pass++;
    n_checks++; if (starts != 1) $display("FAIL single_start_count: got %0d want 1", starts); else n_pass++;
    req = 4'b0000;
    tick();
    n_checks++; if ({busy, ack, grant} !== 9'd0) $display("FAIL single_after: got busy=%b ack=%b grant=%b want all 0", busy, ack, grant); else n_pass++;
  endtask

  task automatic test_contention();
    int   prods [4] = '{30, 56, 65025, 0};
    int   last;
    logic ok;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    a_in = {8'd0, 8'd255, 8'd7, 8'd5};
    b_in = {8'd9, 8'd255, 8'd8, 8'd6};
    req  = 4'b1111;
    last = cycle;
    for (int i = 0; i < 4; i++) begin
      wait_ack(30, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL contention_ack_timeout_%0d: got no ack want ack", i); else n_pass++;
      n_checks++; if (ack !== (4'b0001 << i)) $display("FAIL contention_order_%0d: got %b want %b", i, ack, 4'b0001 << i); else n_pass++;
      n_checks++; if (resp_product !== 16'(prods[i])) $display("FAIL contention_product_%0d: got %0d want %0d", i, resp_product, prods[i]); else n_pass++;
      n_checks++; if (cycle - last != ((i == 0) ? 5 : 6)) $display("FAIL contention_gap_%0d: got %0d want %0d", i, cycle - last, (i == 0) ? 5 : 6); else n_pass++;
      last = cycle;
      req[i] = 1'b0;
    end
    tick();
    n_checks++; if (grant_bad != 0) $display("FAIL grant_onehot: got %0d bad cycles want 0", grant_bad); else n_pass++;
  endtask

  task automatic test_pointer_wrap();
    logic ok;
    a_in = {8'd0, 8'd10, 8'd0, 8'd2};
    b_in = {8'd0, 8'd10, 8'd0, 8'd3};
    req  = 4'b0100;
    wait_ack(30, ok);
    n_checks++; if (!ok || ack !== 4'b0100 || resp_product !== 16'd100) $display("FAIL wrap_first: got ok=%b ack=%b product=%0d want ack=0100 product=100", ok, ack, resp_product); else n_pass++;
    req = 4'b0101;
    wait_ack(30, ok);
    n_checks++; if (!ok || ack !== 4'b0001 || resp_product !== 16'd6) $display("FAIL wrap_second: got ok=%b ack=%b product=%0d want ack=0001 product=6", ok, ack, resp_product); else n_pass++;
    req = 4'b0100;
    wait_ack(30, ok);
    n_checks++; if (!ok || ack !== 4'b0100 || resp_product !== 16'd100) $display("FAIL wrap_third: got ok=%b ack=%b product=%0d want ack=0100 product=100", ok, ack, resp_product); else n_pass++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    int   t0;
    logic ok;
    m_en = 1'b0;
    a_in[15:8] = 8'd3;
    b_in[15:8] = 8'd3;
    req = 4'b0010;
    t0  = cycle;
    wait_ack(100, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL timeout_no_ack: got no ack want ack within 100 cycles"); else n_pass++;
    n_checks++; if (cycle - t0 != 66) $display("FAIL timeout_latency: got %0d want 66", cycle - t0); else n_pass++;
    n_checks++; if ({ack, resp_err} !== {4'b0010, 1'b1}) $display("FAIL timeout_err: got ack=%b err=%b want ack=0010 err=1", ack, resp_err); else n_pass++;
    n_checks++; if (resp_product !== 16'd0) $display("FAIL timeout_product: got %0d want 0", resp_product); else n_pass++;
    req  = 4'b0000;
    m_en = 1'b1;
    tick();
    a_in[15:8] = 8'd12;
    b_in[15:8] = 8'd12;
    req = 4'b0010;
    t0  = cycle;
    wait_ack(30, ok);
    n_checks++; if (!ok || ack !== 4'b0010 || resp_product !== 16'd144 || resp_err !== 1'b0 || cycle - t0 != 5) $display("FAIL timeout_recover: got ok=%b ack=%b product=%0d err=%b lat=%0d want ack=0010 product=144 err=0 lat=5", ok, ack, resp_product, resp_err, cycle - t0); else n_pass++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic ok;
    a_in = {8'd7, 8'd0, 8'd0, 8'd5};
    b_in = {8'd7, 8'd0, 8'd0, 8'd5};
    req  = 4'b1001;
    tick();
    n_checks++; if (grant !== 4'b1000) $display("FAIL midreset_pre_grant: got %b want 1000", grant); else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if ({grant, ack, busy, mul_start, resp_err} !== 11'd0) $display("FAIL midreset_outputs: got grant=%b ack=%b busy=%b start=%b err=%b want all 0", grant, ack, busy, mul_start, resp_err); else n_pass++;
    n_checks++; if ({mul_a, mul_b, resp_product} !== 32'd0) $display("FAIL midreset_data: got %h want 0", {mul_a, mul_b, resp_product}); else n_pass++;
    rst = 1'b1;
    wait_ack(30, ok);
    n_checks++; if (!ok || ack !== 4'b0001 || resp_product !== 16'd25) $display("FAIL midreset_restart: got ok=%b ack=%b product=%0d want ack=0001 product=25", ok, ack, resp_product); else n_pass++;
    req = 4'b1000;
    wait_ack(30, ok);
    n_checks++; if (!ok || ack !== 4'b1000 || resp_product !== 16'd49) $display("FAIL midreset_next: got ok=%b ack=%b product=%0d want ack=1000 product=49", ok, ack, resp_product); else n_pass++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_glitches();
    logic ok;
    int   bad;
    a_in[7:0] = 8'd9;
    b_in[7:0] = 8'd9;
    req = 4'b0001;
    tick();
    tick();
    req = 4'b0000;
    a_in[7:0] = 8'd1;
    tick();
    n_checks++; if (mul_a !== 8'd9) $display("FAIL glitch_operand_hold: got %0d want 9", mul_a); else n_pass++;
    wait_ack(30, ok);
    n_checks++; if (!ok || ack !== 4'b0001 || resp_product !== 16'd81 || resp_err !== 1'b0) $display("FAIL glitch_dropped_req: got ok=%b ack=%b product=%0d err=%b want ack=0001 product=81 err=0", ok, ack, resp_product, resp_err); else n_pass++;
    tick();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      if (ack != 4'd0 || busy || grant != 4'd0 || resp_product != 16'd0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) $display("FAIL glitch_idle_done: got %0d disturbed cycles want 0", bad); else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    cycle     = 0;
    grant_bad = 0;
    rst       = 1'b0;
    req       = 4'd0;
    a_in      = 32'd0;
    b_in      = 32'd0;
    m_en      = 1'b1;
    inj_done  = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_pointer_wrap();
    test_timeout();
    test_reset_mid_wait();
    test_glitches();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
